// File: rtl/wb_dest_hazard_tracker.sv
// wb_dest_hazard_tracker
//   Tracks the destination registers of the instructions in EX, MEM and WB.
//   It compares them against the rs/rt sources of the instruction in ID and
//   drives the ID stall plus the per-operand forwarding selects.
//   fwd encoding: 00 regfile, 01 EX, 10 MEM, 11 WB.
//   Optional feature macro: HAZARD_FWD_EN
//     defined   -> full forwarding; stall only on load-use against EX.
//     undefined -> no forwarding network; stall on any EX/MEM match.
//                  The write-first regfile covers WB.
//   stall/fwd are combinational from the slot registers and the ID sources.
//   This gives zero-latency answers to the decode stage.
module wb_dest_hazard_tracker #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              issue_valid_i,
  input  logic              issue_wr_en_i,
  input  logic              issue_load_i,
  input  logic [REG_AW-1:0] issue_dst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // A slot is live only when valid and not targeting the hard-wired zero
  // register. That also guarantees a zero source address never matches.
  function automatic logic src_hit(input logic              vld,
                                   input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] src);
    return vld && (dst != '0) && (dst == src);
  endfunction

  // Youngest matching stage wins.
  function automatic logic [1:0] fwd_sel(input logic hit_ex,
                                         input logic hit_mem,
                                         input logic hit_wb);
    logic [1:0] sel;
    if (hit_ex) begin
      sel = 2'b01;
    end else if (hit_mem) begin
      sel = 2'b10;
    end else if (hit_wb) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Stage slots. The load flag only matters while the producer sits in EX.
  // MEM and WB therefore carry just valid + destination.
  logic              ex_vld_q,  ex_vld_d;
  logic              ex_load_q, ex_load_d;
  logic [REG_AW-1:0] ex_dst_q,  ex_dst_d;
  logic              mem_vld_q;
  logic [REG_AW-1:0] mem_dst_q;
  logic              wb_vld_q;
  logic [REG_AW-1:0] wb_dst_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       issue_ok_s;
  logic       rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;

  assign rs_ex_s  = src_hit(ex_vld_q,  ex_dst_q,  id_rs_i);
  assign rt_ex_s  = src_hit(ex_vld_q,  ex_dst_q,  id_rt_i);
  assign rs_mem_s = src_hit(mem_vld_q, mem_dst_q, id_rs_i);
  assign rt_mem_s = src_hit(mem_vld_q, mem_dst_q, id_rt_i);

`ifdef HAZARD_FWD_EN
  logic rs_wb_s, rt_wb_s;
  assign rs_wb_s = src_hit(wb_vld_q, wb_dst_q, id_rs_i);
  assign rt_wb_s = src_hit(wb_vld_q, wb_dst_q, id_rt_i);

  // Forwarding covers every ALU result; only a load still in EX must wait a cycle.
  always_comb begin
    stall_s = ex_load_q && (rs_ex_s || rt_ex_s);
    fwd_a_s = fwd_sel(rs_ex_s, rs_mem_s, rs_wb_s);
    fwd_b_s = fwd_sel(rt_ex_s, rt_mem_s, rt_wb_s);
  end
`else
  // Without forwarding, any producer still in EX or MEM blocks ID.
  always_comb begin
    stall_s = rs_ex_s || rt_ex_s || rs_mem_s || rt_mem_s;
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
  end

  // The WB slot and the load flag are only consulted by the forwarding network.
  logic unused_s;
  assign unused_s = ^{ex_load_q, wb_vld_q, wb_dst_q};
`endif

  // Next EX contents: the issuing instruction, or a bubble on stall/flush/no issue.
  always_comb begin
    issue_ok_s = issue_valid_i && !stall_s && !flush_i;
    if (issue_ok_s) begin
      ex_vld_d  = issue_wr_en_i;
      ex_load_d = issue_load_i;
      ex_dst_d  = issue_dst_i;
    end else begin
      ex_vld_d  = 1'b0;
      ex_load_d = 1'b0;
      ex_dst_d  = '0;
    end
  end

  // Saturating count of stall cycles; a flushed cycle is not counted.
  always_comb begin
    if (stall_s && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Advance the slot pipeline and the counter; reset forgets everything in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_vld_q    <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_dst_q    <= '0;
      mem_vld_q   <= 1'b0;
      mem_dst_q   <= '0;
      wb_vld_q    <= 1'b0;
      wb_dst_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_vld_q    <= mem_vld_q;
      wb_dst_q    <= mem_dst_q;
      mem_vld_q   <= ex_vld_q;
      mem_dst_q   <= ex_dst_q;
      ex_vld_q    <= ex_vld_d;
      ex_load_q   <= ex_load_d;
      ex_dst_q    <= ex_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall_s;
  assign fwd_a_o     = fwd_a_s;
  assign fwd_b_o     = fwd_b_s;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_wb_dest_hazard_tracker.sv
// Bench for wb_dest_hazard_tracker: directed scenarios plus a randomized run.
// Every cycle is compared against a behavioural model of the EX/MEM/WB occupancy.
module tb_wb_dest_hazard_tracker;

  localparam int AW = 5;
  localparam int CW = 4;  // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          reset_n;
  logic          issue_valid, issue_wr_en, issue_load, flush;
  logic [AW-1:0] issue_dst, id_rs, id_rt;
  logic          stall;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  wb_dest_hazard_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .issue_valid_i(issue_valid),
    .issue_wr_en_i(issue_wr_en),
    .issue_load_i (issue_load),
    .issue_dst_i  (issue_dst),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .flush_i      (flush),
    .stall_o      (stall),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .stall_cnt_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {bit vld; bit load; int dst;} slot_t;
  slot_t pipe[3];
  int    m_cnt;
  int    cnt_max = (1 << CW) - 1;

  function automatic bit m_hit(int i, int src);
    return pipe[i].vld && pipe[i].dst != 0 && pipe[i].dst == src;
  endfunction

  function automatic int m_fwd(int src);
`ifdef HAZARD_FWD_EN
    for (int i = 0; i < 3; i++) if (m_hit(i, src)) return i + 1;
`endif
    return 0;
  endfunction

  function automatic bit m_stall(int rs, int rt);
`ifdef HAZARD_FWD_EN
    return pipe[0].load && (m_hit(0, rs) || m_hit(0, rt));
`else
    return m_hit(0, rs) || m_hit(0, rt) || m_hit(1, rs) || m_hit(1, rt);
`endif
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
    m_cnt = 0;
  endtask

  logic          o_stall;
  logic [1:0]    o_fa, o_fb;
  logic [CW-1:0] o_cnt;

  // Called at a negedge: drive, check against model, advance model, move to next negedge.
  task automatic step(input bit v, input bit w, input bit l, input int d,
                      input int rs, input int rt, input bit f);
    bit s;
    issue_valid = v; issue_wr_en = w; issue_load = l; issue_dst = AW'(d);
    id_rs = AW'(rs); id_rt = AW'(rt); flush = f;
    #1;
    o_stall = stall; o_fa = fwd_a; o_fb = fwd_b; o_cnt = stall_cnt;
    s = m_stall(rs, rt);
    check_eq("stall", 32'(stall), 32'(s));
    check_eq("fwd_a", 32'(fwd_a), 32'(m_fwd(rs)));
    check_eq("fwd_b", 32'(fwd_b), 32'(m_fwd(rt)));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (v && !s && !f) pipe[0] = '{w, l, d};
    else               pipe[0] = '{0, 0, 0};
    if (s && !f && m_cnt < cnt_max) m_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Async reset dropped between edges: outputs must clear without a clock edge.
  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_fwd_a", 32'(fwd_a), 32'd0);
    check_eq("rst_fwd_b", 32'(fwd_b), 32'd0);
    check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
    m_clear();
    issue_valid = 1'b0; flush = 1'b0; id_rs = '0; id_rt = '0;
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; issue_wr_en = 1'b0; issue_load = 1'b0;
    issue_dst = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ALU chain: dst=5 then id_rs=5 for four cycles
    step(1, 1, 0, 5, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 0);
`ifdef HAZARD_FWD_EN
    check_eq("s1_fwd_ex", 32'(o_fa), 32'd1);
    step(0, 0, 0, 0, 5, 0, 0);
    check_eq("s1_fwd_mem", 32'(o_fa), 32'd2);
    step(0, 0, 0, 0, 5, 0, 0);
    check_eq("s1_fwd_wb", 32'(o_fa), 32'd3);
`else
    check_eq("s1_stall_ex", 32'(o_stall), 32'd1);
    step(0, 0, 0, 0, 5, 0, 0);
    check_eq("s1_stall_mem", 32'(o_stall), 32'd1);
    step(0, 0, 0, 0, 5, 0, 0);
    check_eq("s1_nostall_wb", 32'(o_stall), 32'd0);
`endif
    step(0, 0, 0, 0, 5, 0, 0);
    check_eq("s1_drained", 32'(o_fa), 32'd0);
    do_reset();

    // Load-use: load dst=8 then id_rt=8
    step(1, 1, 1, 8, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8, 0);
    check_eq("s2_stall", 32'(o_stall), 32'd1);
    step(0, 0, 0, 0, 0, 8, 0);
    check_eq("s2_cnt", 32'(o_cnt), 32'd1);
`ifdef HAZARD_FWD_EN
    check_eq("s2_after", 32'(o_stall), 32'd0);
    check_eq("s2_fwd_mem", 32'(o_fb), 32'd2);
`else
    check_eq("s2_after", 32'(o_stall), 32'd1);
`endif
    do_reset();

    // Register 0 never hazards
    step(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check_eq("s3_stall", 32'(o_stall), 32'd0);
      check_eq("s3_fwd", 32'({o_fa, o_fb}), 32'd0);
    end
    do_reset();

    // Priority: dst=3 in MEM and in EX
    step(1, 1, 0, 3, 0, 0, 0);
    step(1, 1, 0, 3, 0, 0, 0);
    step(0, 0, 0, 0, 3, 0, 0);
`ifdef HAZARD_FWD_EN
    check_eq("s4_youngest", 32'(o_fa), 32'd1);
`else
    check_eq("s4_stall", 32'(o_stall), 32'd1);
`endif
    do_reset();

    // Flush during load-use stall
    step(1, 1, 1, 8, 0, 0, 0);
    step(1, 1, 0, 9, 0, 8, 1);
    check_eq("s5_stall", 32'(o_stall), 32'd1);
    step(0, 0, 0, 0, 0, 8, 0);
    check_eq("s5_cnt_held", 32'(o_cnt), 32'd0);
`ifdef HAZARD_FWD_EN
    check_eq("s5_fwd_mem", 32'(o_fb), 32'd2);
`endif
    do_reset();

    // Randomized run with occasional mid-operation resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
